exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception/interrupt controller sitting between the write-back stage and the CSR file. Prioritises the exception flags carried by the committing instruction and samples pending interrupts. Produces the one-cycle CSR exception/ertn strobes with ecode/esubcode. Sequences the pipeline flush and fetch redirect through a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32, PC/address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  instruction present in WB this cycle
- wb_exc  in  6  exception flags: [0] ADEF, [1] SYS, [2] BRK, [3] INE, [4] ALE, [5] ADEM
- wb_ertn  in  1  WB instruction is ertn
- wb_pc  in  ADDR_W  WB instruction PC
- wb_vaddr_in  in  ADDR_W  memory address of WB instruction
- estat_is  in  13  CSR ESTAT.IS
- ecfg_lie  in  13  CSR ECFG.LIE
- crmd_ie  in  1  CSR CRMD.IE
- eentry  in  ADDR_W  exception entry
- era  in  ADDR_W  return address
- wb_ready  out  1  WB may commit this cycle
- wb_ex  out  1  exception strobe to CSR file
- ertn_flush  out  1  ertn strobe to CSR file
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_vaddr  out  ADDR_W  BADV source
- flush  out  1  kill all younger pipeline stages
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  ADDR_W  redirect target
- redirect_ready  in  1  fetch accepts redirect

## Operation
- int_req register: each cycle <= crmd_ie & |(estat_is & ecfg_lie). Reset 0.
- Priority when wb_valid in IDLE: INT (int_req) > ADEF > SYS > BRK > INE > ALE > ADEM > ertn.
- Codes: INT 0x00/0; ADEF 0x08/0; SYS 0x0B/0; BRK 0x0C/0; INE 0x0D/0; ALE 0x09/0; ADEM 0x08/1.
- wb_vaddr = wb_pc for ADEF, wb_vaddr_in otherwise.
- Exception taken: wb_ex=1, flush=1, target latched = eentry.
- ertn taken (no higher event): ertn_flush=1, flush=1, target latched = era.
- wb_ex and ertn_flush are never high together.
- FSM states:
  - IDLE: wb_ready=1. On accept -> REDIR.
  - REDIR: redirect_valid=1, redirect_pc = latched target, flush=1, wb_ready=0. wb_valid, wb_exc, and wb_ertn are ignored. On redirect_ready -> IDLE.
- Reset in any state -> IDLE. All outputs 0, except wb_ready=1. Latched target = 0.

## Timing
- wb_ex, ertn_flush, ecode, esubcode, vaddr: combinational in the accept cycle. The CSR file updates at the next edge.
- redirect_valid rises the cycle after accept; latency 1.
- redirect_valid and redirect_pc stay stable until the cycle redirect_ready=1. The FSM is in IDLE the following cycle.
- A back-to-back accept is possible one cycle after handshake completion.
- The interrupt becomes visible one cycle after estat_is/lie/ie change, via the int_req register.
- An interrupt with wb_valid=0 waits for the next valid WB instruction. It is never taken on a bubble.

## Configuration
- EXC_CTRL_INT_EN defined: interrupt sampling and the INT priority slot are active.
- Undefined: int_req is tied 0, and estat_is, ecfg_lie, and crmd_ie are unused. Only synchronous exceptions and ertn are handled.

## Structure
- Shared package holds:
  - ECODE_*/ESUBCODE_* constants
  - wb_exc bit-index constants
  - FSM state typedef (IDLE, REDIR)
- One natural sub-module: exc_prio_enc. It is the combinational priority encoder {int_req, wb_exc, wb_ertn} -> {take, is_ertn, ecode, esubcode}.

## Test plan
- wb_valid=1, wb_exc=6'b001000 (INE), eentry=0x1C008000 -> wb_ex=1, ecode 0x0D, flush. Next cycle redirect_valid=1, pc 0x1C008000. Held 3 cycles with ready=0, then IDLE after ready=1.
- wb_exc ALE|SYS together -> ecode 0x0B. ADEF with wb_pc=0x1C000003 -> ecode 0x08, sub 0, wb_vaddr=0x1C000003.
- wb_ertn=1, era=0x1C000100 -> ertn_flush=1, wb_ex=0, redirect_pc=0x1C000100.
- estat_is[11]=1, lie[11]=1, ie=1, then wb_valid with INE one cycle later -> ecode 0x00 (INT wins). With ie=0 -> ecode 0x0D.
- wb_valid with new exception during REDIR -> ignored, wb_ready=0. Reset asserted in REDIR -> next cycle redirect_valid=0, wb_ready=1.
- Build without EXC_CTRL_INT_EN, pending interrupt plus plain wb_valid -> no wb_ex.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception/interrupt controller.
// Define EXC_CTRL_INT_EN to enable interrupt sampling (see exc_ctrl.sv).
package exc_ctrl_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  localparam int unsigned EXC_ADEF = 0;
  localparam int unsigned EXC_SYS  = 1;
  localparam int unsigned EXC_BRK  = 2;
  localparam int unsigned EXC_INE  = 3;
  localparam int unsigned EXC_ALE  = 4;
  localparam int unsigned EXC_ADEM = 5;

  typedef enum logic [0:0] {
    StIdle,
    StRedir
  } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: INT > ADEF > SYS > BRK > INE > ALE > ADEM > ertn.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic [5:0] wb_exc,
  input  logic       wb_ertn,
  output logic       take,
  output logic       is_ertn,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  always_comb begin
    take     = 1'b1;
    is_ertn  = 1'b0;
    ecode    = ECODE_INT;
    esubcode = ESUBCODE_NONE;
    if (int_req) begin
      ecode = ECODE_INT;
    end else if (wb_exc[EXC_ADEF]) begin
      ecode = ECODE_ADE;
    end else if (wb_exc[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (wb_exc[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (wb_exc[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (wb_exc[EXC_ALE]) begin
      ecode = ECODE_ALE;
    end else if (wb_exc[EXC_ADEM]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEM;
    end else if (wb_ertn) begin
      is_ertn = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between WB and the CSR file, with flush/redirect sequencing.
// Optional feature macro: EXC_CTRL_INT_EN (interrupt sampling and INT priority slot).
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [5:0]        wb_exc,
  input  logic              wb_ertn,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_vaddr_in,
  input  logic [12:0]       estat_is,
  input  logic [12:0]       ecfg_lie,
  input  logic              crmd_ie,
  input  logic [ADDR_W-1:0] eentry,
  input  logic [ADDR_W-1:0] era,
  output logic              wb_ready,
  output logic              wb_ex,
  output logic              ertn_flush,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [ADDR_W-1:0] wb_vaddr,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready
);

  logic int_req;

`ifdef EXC_CTRL_INT_EN
  logic int_req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= crmd_ie & (|(estat_is & ecfg_lie));
    end
  end

  assign int_req = int_req_q;
`else
  logic unused_int_inputs;

  assign int_req           = 1'b0;
  assign unused_int_inputs = ^{estat_is, ecfg_lie, crmd_ie};
`endif

  logic       take;
  logic       is_ertn;
  logic [5:0] ecode;
  logic [8:0] esubcode;

  exc_prio_enc u_prio_enc (
    .int_req  (int_req),
    .wb_exc   (wb_exc),
    .wb_ertn  (wb_ertn),
    .take     (take),
    .is_ertn  (is_ertn),
    .ecode    (ecode),
    .esubcode (esubcode)
  );

  exc_state_e        state_q;
  logic [ADDR_W-1:0] target_q;
  logic              redirect_valid_q;
  logic              accept;

  // WB inputs are only looked at in idle; an interrupt never fires on a bubble.
  assign accept = (state_q == StIdle) & wb_valid & take & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      target_q         <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q          <= StRedir;
            target_q         <= is_ertn ? era : eentry;
            redirect_valid_q <= 1'b1;
          end
        end
        StRedir: begin
          if (redirect_ready) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= StIdle;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready       = (state_q == StIdle);
  assign wb_ex          = accept & ~is_ertn;
  assign ertn_flush     = accept & is_ertn;
  assign wb_ecode       = wb_ex ? ecode : '0;
  assign wb_esubcode    = wb_ex ? esubcode : '0;
  // ADEF is the only cause that reports the fetch PC as the bad address.
  assign wb_vaddr       = !wb_ex ? '0 :
                          ((ecode == ECODE_ADE) && (esubcode == ESUBCODE_NONE)) ? wb_pc :
                          wb_vaddr_in;
  assign flush          = accept | redirect_valid_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed steps followed by randomized cycles,
// all outputs compared every cycle against a priority-list reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [5:0]  wb_exc;
  logic        wb_ertn;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr_in;
  logic [12:0] estat_is;
  logic [12:0] ecfg_lie;
  logic        crmd_ie;
  logic [31:0] eentry;
  logic [31:0] era;
  logic        wb_ready;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int errors = 0;
  int checks = 0;

  // Cause table in flag-bit order, which is also the priority order below INT.
  localparam logic [5:0] EXC_CODE [6] = '{6'h08, 6'h0B, 6'h0C, 6'h0D, 6'h09, 6'h08};
  localparam logic [8:0] EXC_SUB  [6] = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd1};

  // Reference model state.
  bit          m_busy = 1'b0;
  logic [31:0] m_tgt  = '0;
  bit          m_int  = 1'b0;

  always #5 clk = ~clk;

  exc_ctrl #(
    .ADDR_W (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_exc         (wb_exc),
    .wb_ertn        (wb_ertn),
    .wb_pc          (wb_pc),
    .wb_vaddr_in    (wb_vaddr_in),
    .estat_is       (estat_is),
    .ecfg_lie       (ecfg_lie),
    .crmd_ie        (crmd_ie),
    .eentry         (eentry),
    .era            (era),
    .wb_ready       (wb_ready),
    .wb_ex          (wb_ex),
    .ertn_flush     (ertn_flush),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_vaddr       (wb_vaddr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic step();
    bit          e_ex, e_er, found;
    logic [5:0]  e_code;
    logic [8:0]  e_sub;
    logic [31:0] e_va;
    e_ex = 0; e_er = 0; found = 0; e_code = '0; e_sub = '0; e_va = '0;
    if (!m_busy && wb_valid && !reset) begin
      if (m_int) begin
        e_ex = 1; e_va = wb_vaddr_in;
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (!found && wb_exc[i]) begin
            found = 1; e_ex = 1; e_code = EXC_CODE[i]; e_sub = EXC_SUB[i];
            e_va = (i == 0) ? wb_pc : wb_vaddr_in;
          end
        end
        if (!found && wb_ertn) e_er = 1;
      end
    end
    chk("wb_ready", wb_ready, !m_busy);
    chk("wb_ex", wb_ex, e_ex);
    chk("ertn_flush", ertn_flush, e_er);
    chk("wb_ecode", wb_ecode, e_code);
    chk("wb_esubcode", wb_esubcode, e_sub);
    chk("wb_vaddr", wb_vaddr, e_va);
    chk("flush", flush, e_ex | e_er | m_busy);
    chk("redirect_valid", redirect_valid, m_busy);
    chk("redirect_pc", redirect_pc, m_tgt);
    if (reset) begin
      m_busy = 0; m_tgt = '0;
    end else if (e_ex || e_er) begin
      m_busy = 1; m_tgt = e_er ? era : eentry;
    end else if (m_busy && redirect_ready) begin
      m_busy = 0;
    end
`ifdef EXC_CTRL_INT_EN
    m_int = !reset && crmd_ie && ((estat_is & ecfg_lie) != 0);
`else
    m_int = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    wb_valid = 0; redirect_ready = 1;
    settle(); step();
    redirect_ready = 0;
  endtask

  initial begin
    reset = 1; wb_valid = 0; wb_exc = '0; wb_ertn = 0; wb_pc = 32'h1C00_0000;
    wb_vaddr_in = 32'h0000_1234; estat_is = '0; ecfg_lie = '0; crmd_ie = 0;
    eentry = 32'h1C00_8000; era = 32'h1C00_0100; redirect_ready = 0;
    @(posedge clk); #1;
    settle(); step();
    settle(); step();
    reset = 0;
    settle();
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    step();

    // INE, held redirect for 3 cycles, then handshake.
    wb_valid = 1; wb_exc = 6'b001000;
    settle();
    chk("ine_ex", wb_ex, 1);
    chk("ine_ecode", wb_ecode, 6'h0D);
    chk("ine_flush", flush, 1);
    step();
    wb_valid = 0; wb_exc = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ine_rv_hold", redirect_valid, 1);
      chk("ine_rpc_hold", redirect_pc, 32'h1C00_8000);
      step();
    end
    redirect_ready = 1;
    settle(); step();
    redirect_ready = 0;
    settle();
    chk("ine_back_idle", wb_ready, 1);
    chk("ine_rv_drop", redirect_valid, 0);
    step();

    // ALE|SYS -> SYS wins; back-to-back accept right after handshake.
    wb_valid = 1; wb_exc = 6'b010010;
    settle();
    chk("sys_over_ale", wb_ecode, 6'h0B);
    step();
    wb_valid = 0; redirect_ready = 1;
    settle(); step();
    redirect_ready = 0;

    // ADEF reports the PC as bad address.
    wb_valid = 1; wb_exc = 6'b000001; wb_pc = 32'h1C00_0003;
    settle();
    chk("adef_ecode", wb_ecode, 6'h08);
    chk("adef_sub", wb_esubcode, 0);
    chk("adef_vaddr", wb_vaddr, 32'h1C00_0003);
    step();
    drain();

    // ertn.
    wb_valid = 1; wb_exc = '0; wb_ertn = 1;
    settle();
    chk("ertn_flush", ertn_flush, 1);
    chk("ertn_no_ex", wb_ex, 0);
    step();
    wb_valid = 0; wb_ertn = 0;
    settle();
    chk("ertn_rpc", redirect_pc, 32'h1C00_0100);
    step();
    drain();

    // Interrupt pending one cycle before an INE instruction.
    estat_is = 13'h0800; ecfg_lie = 13'h0800; crmd_ie = 1;
    settle(); step();
    wb_valid = 1; wb_exc = 6'b001000;
    settle();
`ifdef EXC_CTRL_INT_EN
    chk("int_wins", wb_ecode, 6'h00);
    chk("int_ex", wb_ex, 1);
`else
    chk("int_off_ine", wb_ecode, 6'h0D);
`endif
    step();
    drain();
    crmd_ie = 0;
    settle(); step();
    wb_valid = 1; wb_exc = 6'b001000;
    settle();
    chk("ie_off_ine", wb_ecode, 6'h0D);
    step();

    // New exception during REDIR is ignored; reset in REDIR returns to idle.
    wb_exc = 6'b000010;
    settle();
    chk("redir_not_ready", wb_ready, 0);
    chk("redir_ignore_ex", wb_ex, 0);
    step();
    wb_valid = 0; wb_exc = '0; reset = 1;
    settle(); step();
    reset = 0;
    settle();
    chk("rst_redir_rv", redirect_valid, 0);
    chk("rst_redir_ready", wb_ready, 1);
    step();

    // Pending interrupt with a plain instruction.
    crmd_ie = 1;
    settle(); step();
    wb_valid = 1; wb_exc = '0; wb_ertn = 0;
    settle();
`ifdef EXC_CTRL_INT_EN
    chk("int_plain_ex", wb_ex, 1);
`else
    chk("noint_plain_ex", wb_ex, 0);
`endif
    step();
    drain();

    // Randomized cycles.
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 59) == 0);
      wb_valid       = $urandom_range(0, 1);
      wb_exc         = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      wb_ertn        = ($urandom_range(0, 3) == 0);
      wb_pc          = $urandom;
      wb_vaddr_in    = $urandom;
      estat_is       = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h0;
      ecfg_lie       = 13'($urandom);
      crmd_ie        = $urandom_range(0, 1);
      eentry         = $urandom;
      era            = $urandom;
      redirect_ready = $urandom_range(0, 1);
      settle(); step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
